camera_capture_ctrl: RTL and testbench

Frame-capture sequencer between the OV5640 pixel buffer and the downstream write FIFO. It arms on a software start and aligns to the next frame boundary on `vsync`. During the frame it forwards each completed 32-bit buffer word (`buff_done` / `data_buffer`) into the FIFO with a generated byte address, then reports frame completion, frame count and overflow to the register block.

---
 rtl/camera_capture_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_camera_capture_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/camera_capture_ctrl.sv
// Frame-capture sequencer: arms on start, aligns to the vsync frame boundary and
// forwards buffered words to the write FIFO with byte addresses. Optional macro CAPTURE_IRQ_EN adds irq/irq_clr.
module camera_capture_ctrl #(
    parameter int BUFF_LENGTH        = 32,
    parameter int AXI4_ADDRESS_WIDTH = 32,
    parameter int WORD_CNT_WIDTH     = 20
) (
    input  logic                          pclk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          stop,
    input  logic                          continuous,
    input  logic [AXI4_ADDRESS_WIDTH-1:0] base_addr,
    input  logic [WORD_CNT_WIDTH-1:0]     frame_words,
    input  logic                          vsync,
    input  logic                          buff_done,
    input  logic [BUFF_LENGTH-1:0]        data_buffer,
    input  logic                          fifo_full,
`ifdef CAPTURE_IRQ_EN
    input  logic                          irq_clr,
    output logic                          irq,
`endif
    output logic                          fifo_wr_en,
    output logic [BUFF_LENGTH-1:0]        fifo_wdata,
    output logic [AXI4_ADDRESS_WIDTH-1:0] fifo_waddr,
    output logic                          busy,
    output logic                          frame_done,
    output logic [15:0]                   frame_cnt,
    output logic [WORD_CNT_WIDTH-1:0]     word_cnt,
    output logic                          overflow
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_SYNC,
        S_CAPTURE,
        S_DONE
    } state_e;

    localparam logic [WORD_CNT_WIDTH-1:0] WC_ONE = 1;

    state_e                          state_q, state_d;
    logic                            cont_q, cont_d;
    logic [AXI4_ADDRESS_WIDTH-1:0]   base_q, base_d;
    logic [WORD_CNT_WIDTH-1:0]       idx_q, idx_d;
    logic [WORD_CNT_WIDTH-1:0]       word_cnt_q, word_cnt_d;
    logic                            overflow_q, overflow_d;
    logic                            wr_en_q, wr_en_d;
    logic [BUFF_LENGTH-1:0]          wdata_q, wdata_d;
    logic [AXI4_ADDRESS_WIDTH-1:0]   waddr_q, waddr_d;
    logic                            frame_done_q, frame_done_d;
    logic [15:0]                     frame_cnt_q, frame_cnt_d;
    logic                            limit_hit;
    logic                            accept;

    always_comb begin
        state_d      = state_q;
        cont_d       = cont_q;
        base_d       = base_q;
        idx_d        = idx_q;
        word_cnt_d   = word_cnt_q;
        overflow_d   = overflow_q;
        wr_en_d      = 1'b0;
        wdata_d      = wdata_q;
        waddr_d      = waddr_q;
        frame_done_d = 1'b0;
        frame_cnt_d  = frame_cnt_q;

        limit_hit = (frame_words != '0) && (idx_q == frame_words);
        accept    = (state_q == S_CAPTURE) && buff_done && !stop && !limit_hit;

        // A dropped word still consumes its address slot so the frame layout stays intact.
        if (accept) begin
            idx_d = idx_q + WC_ONE;
            if (!fifo_full) begin
                wr_en_d    = 1'b1;
                wdata_d    = data_buffer;
                waddr_d    = base_q + (AXI4_ADDRESS_WIDTH'(idx_q) << 2);
                word_cnt_d = word_cnt_q + WC_ONE;
            end else begin
                overflow_d = 1'b1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (start && !stop) begin
                    state_d    = S_ARM;
                    cont_d     = continuous;
                    overflow_d = 1'b0;
                end
            end
            S_ARM: begin
                if (vsync) state_d = S_SYNC;
            end
            S_SYNC: begin
                if (!vsync) begin
                    state_d    = S_CAPTURE;
                    base_d     = base_addr;
                    idx_d      = '0;
                    word_cnt_d = '0;
                end
            end
            S_CAPTURE: begin
                if (vsync) state_d = S_DONE;
            end
            S_DONE: begin
                frame_done_d = 1'b1;
                frame_cnt_d  = frame_cnt_q + 16'd1;
                state_d      = cont_q ? S_SYNC : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (stop) begin
            state_d      = S_IDLE;
            frame_done_d = 1'b0;
            frame_cnt_d  = frame_cnt_q;
        end
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cont_q       <= 1'b0;
            base_q       <= '0;
            idx_q        <= '0;
            word_cnt_q   <= '0;
            overflow_q   <= 1'b0;
            wr_en_q      <= 1'b0;
            wdata_q      <= '0;
            waddr_q      <= '0;
            frame_done_q <= 1'b0;
            frame_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            cont_q       <= cont_d;
            base_q       <= base_d;
            idx_q        <= idx_d;
            word_cnt_q   <= word_cnt_d;
            overflow_q   <= overflow_d;
            wr_en_q      <= wr_en_d;
            wdata_q      <= wdata_d;
            waddr_q      <= waddr_d;
            frame_done_q <= frame_done_d;
            frame_cnt_q  <= frame_cnt_d;
        end
    end

`ifdef CAPTURE_IRQ_EN
    logic irq_q, irq_d;
    logic ovf_prev_q, ovf_prev_d;

    // Set has priority over a same-cycle clear so no event is lost.
    always_comb begin
        ovf_prev_d = overflow_q;
        irq_d      = irq_q;
        if (irq_clr) irq_d = 1'b0;
        if (frame_done_q || (overflow_q && !ovf_prev_q)) irq_d = 1'b1;
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            irq_q      <= 1'b0;
            ovf_prev_q <= 1'b0;
        end else begin
            irq_q      <= irq_d;
            ovf_prev_q <= ovf_prev_d;
        end
    end

    assign irq = irq_q;
`endif

    assign fifo_wr_en = wr_en_q;
    assign fifo_wdata = wdata_q;
    assign fifo_waddr = waddr_q;
    assign busy       = (state_q != S_IDLE);
    assign frame_done = frame_done_q;
    assign frame_cnt  = frame_cnt_q;
    assign word_cnt   = word_cnt_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_camera_capture_ctrl.sv
// Directed bench for camera_capture_ctrl: single shot, mid-frame arm, overflow,
// limit/continuous, abort and async reset, with hand-computed expectations.
module tb_camera_capture_ctrl;

    logic        pclk = 1'b0;
    logic        rst_n;
    logic        start, stop, continuous;
    logic [31:0] base_addr;
    logic [19:0] frame_words;
    logic        vsync, buff_done, fifo_full;
    logic [31:0] data_buffer;
    logic        fifo_wr_en;
    logic [31:0] fifo_wdata, fifo_waddr;
    logic        busy, frame_done, overflow;
    logic [15:0] frame_cnt;
    logic [19:0] word_cnt;
`ifdef CAPTURE_IRQ_EN
    logic        irq_clr, irq;
`endif

    int n_chk  = 0;
    int n_fail = 0;
    int fd_cnt = 0;
    logic [31:0] wa_q[$];
    logic [31:0] wd_q[$];

    camera_capture_ctrl dut (
        .pclk(pclk), .rst_n(rst_n), .start(start), .stop(stop),
        .continuous(continuous), .base_addr(base_addr), .frame_words(frame_words),
        .vsync(vsync), .buff_done(buff_done), .data_buffer(data_buffer),
        .fifo_full(fifo_full),
`ifdef CAPTURE_IRQ_EN
        .irq_clr(irq_clr), .irq(irq),
`endif
        .fifo_wr_en(fifo_wr_en), .fifo_wdata(fifo_wdata), .fifo_waddr(fifo_waddr),
        .busy(busy), .frame_done(frame_done), .frame_cnt(frame_cnt),
        .word_cnt(word_cnt), .overflow(overflow)
    );

    always #5 pclk = ~pclk;

    always @(negedge pclk) begin
        if (fifo_wr_en) begin
            wa_q.push_back(fifo_waddr);
            wd_q.push_back(fifo_wdata);
        end
        if (frame_done) fd_cnt++;
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge pclk);
    endtask

    task automatic pulse_start(input logic cont);
        start = 1'b1; continuous = cont;
        cyc(1);
        start = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] d, input logic full);
        buff_done = 1'b1; data_buffer = d; fifo_full = full;
        cyc(1);
        buff_done = 1'b0; fifo_full = 1'b0;
        cyc(1);
    endtask

    task automatic clr_log();
        wa_q.delete();
        wd_q.delete();
    endtask

    task automatic chk_writes(input string tag, input logic [31:0] base, input int n,
                              input logic [31:0] exp_d[$], input int slot[$]);
        chk({tag, "_n"}, 64'(wa_q.size()), 64'(n));
        for (int i = 0; i < n && i < wa_q.size(); i++) begin
            chk($sformatf("%s_a%0d", tag, i), 64'(wa_q[i]), 64'(base + 32'(4 * slot[i])));
            chk($sformatf("%s_d%0d", tag, i), 64'(wd_q[i]), 64'(exp_d[i]));
        end
    endtask

    initial begin
        logic [31:0] ed[$];
        int          sl[$];
        int          fd0;

        rst_n = 1'b0; start = 0; stop = 0; continuous = 0; base_addr = 32'h1000;
        frame_words = '0; vsync = 1'b1; buff_done = 0; fifo_full = 0; data_buffer = '0;
`ifdef CAPTURE_IRQ_EN
        irq_clr = 1'b0;
`endif
        cyc(3);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_wr_en", 64'(fifo_wr_en), 0);
        chk("rst_frame_cnt", 64'(frame_cnt), 0);
        chk("rst_word_cnt", 64'(word_cnt), 0);
        chk("rst_overflow", 64'(overflow), 0);
        rst_n = 1'b1;
        cyc(1);

        // single shot
        pulse_start(1'b0);
        chk("arm_busy", 64'(busy), 1);
        cyc(2);
        vsync = 1'b0;
        cyc(2);
        clr_log();
        ed.delete(); sl.delete();
        for (int i = 1; i <= 8; i++) begin
            send_word(32'(i * 'h11), 1'b0);
            ed.push_back(32'(i * 'h11)); sl.push_back(i - 1);
        end
        vsync = 1'b1;
        cyc(1);
        chk("fd_lat1", 64'(frame_done), 0);
        cyc(1);
        chk("fd_lat2", 64'(frame_done), 1);
        chk("ss_frame_cnt", 64'(frame_cnt), 1);
`ifdef CAPTURE_IRQ_EN
        chk("irq_before", 64'(irq), 0);
`endif
        cyc(1);
        chk("fd_pulse_end", 64'(frame_done), 0);
`ifdef CAPTURE_IRQ_EN
        chk("irq_set", 64'(irq), 1);
        irq_clr = 1'b1; cyc(1); irq_clr = 1'b0; cyc(1);
        chk("irq_clr", 64'(irq), 0);
`endif
        cyc(2);
        chk_writes("ss", 32'h1000, 8, ed, sl);
        chk("ss_fd_cnt", 64'(fd_cnt), 1);
        chk("ss_word_cnt", 64'(word_cnt), 8);
        chk("ss_idle", 64'(busy), 0);

        // mid-frame arm, then overflow on 3rd of 5 words
        vsync = 1'b0; base_addr = 32'h0;
        cyc(2);
        pulse_start(1'b0);
        clr_log();
        send_word(32'hAAAA_0001, 1'b0);
        send_word(32'hAAAA_0002, 1'b0);
        send_word(32'hAAAA_0003, 1'b0);
        chk("midarm_nowr", 64'(wa_q.size()), 0);
        vsync = 1'b1; cyc(2);
        vsync = 1'b0; cyc(2);
        chk("midarm_nowr2", 64'(wa_q.size()), 0);
        base_addr = 32'hDEAD_0000;
        ed.delete(); sl.delete();
        for (int i = 1; i <= 5; i++) begin
            send_word(32'(i), i == 3);
            if (i != 3) begin ed.push_back(32'(i)); sl.push_back(i - 1); end
        end
        chk_writes("ovf", 32'h0, 4, ed, sl);
        chk("ovf_flag", 64'(overflow), 1);
        chk("ovf_word_cnt", 64'(word_cnt), 4);
        vsync = 1'b1; cyc(4);
        chk("ovf_frame_cnt", 64'(frame_cnt), 2);
        chk("ovf_sticky", 64'(overflow), 1);

        // limit 4, continuous, 3 frames with distinct bases
        frame_words = 20'd4;
        pulse_start(1'b1);
        chk("ovf_cleared", 64'(overflow), 0);
        for (int f = 0; f < 3; f++) begin
            base_addr = 32'h2000 + 32'(f * 'h1000);
            cyc(2);
            vsync = 1'b0; cyc(1);
            base_addr = 32'hBEEF_0000;
            cyc(1);
            clr_log();
            ed.delete(); sl.delete();
            for (int i = 0; i < 6; i++) begin
                send_word(32'(f * 16 + i), 1'b0);
                if (i < 4) begin ed.push_back(32'(f * 16 + i)); sl.push_back(i); end
            end
            vsync = 1'b1; cyc(4);
            chk_writes($sformatf("lim%0d", f), 32'h2000 + 32'(f * 'h1000), 4, ed, sl);
            chk($sformatf("lim%0d_ovf", f), 64'(overflow), 0);
        end
        chk("cont_frame_cnt", 64'(frame_cnt), 5);
        chk("cont_word_cnt", 64'(word_cnt), 4);
        chk("cont_busy", 64'(busy), 1);
        stop = 1'b1; cyc(1); stop = 1'b0;
        chk("cont_stop", 64'(busy), 0);

        // abort with stop coincident with buff_done
        frame_words = '0; base_addr = 32'h5000;
        pulse_start(1'b0);
        cyc(2);
        vsync = 1'b0; cyc(2);
        clr_log();
        send_word(32'h5A5A_0000, 1'b0);
        send_word(32'h5A5A_0001, 1'b0);
        fd0 = fd_cnt;
        buff_done = 1'b1; stop = 1'b1; data_buffer = 32'h5A5A_0002;
        cyc(1);
        buff_done = 1'b0; stop = 1'b0;
        chk("abort_nowr", 64'(fifo_wr_en), 0);
        chk("abort_idle", 64'(busy), 0);
        vsync = 1'b1; cyc(4);
        chk("abort_wrs", 64'(wa_q.size()), 2);
        chk("abort_no_fd", 64'(fd_cnt - fd0), 0);
        chk("abort_frame_cnt", 64'(frame_cnt), 5);

        // async reset mid-frame right after a write
        pulse_start(1'b0);
        cyc(2);
        vsync = 1'b0; cyc(2);
        send_word(32'h0000_0077, 1'b1);
        buff_done = 1'b1; data_buffer = 32'h0000_0088;
        cyc(1);
        buff_done = 1'b0;
        chk("pre_rst_wr", 64'(fifo_wr_en), 1);
        chk("pre_rst_ovf", 64'(overflow), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_wr_en", 64'(fifo_wr_en), 0);
        chk("arst_wdata", 64'(fifo_wdata), 0);
        chk("arst_waddr", 64'(fifo_waddr), 0);
        chk("arst_busy", 64'(busy), 0);
        chk("arst_frame_cnt", 64'(frame_cnt), 0);
        chk("arst_word_cnt", 64'(word_cnt), 0);
        chk("arst_overflow", 64'(overflow), 0);
        cyc(2);
        rst_n = 1'b1;
        cyc(2);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
